// File: rtl/spi_frame_master.sv
// Initiator for the 16-bit SPI register-access frame: serialises one command per
// start pulse, samples miso on reads and reports read data with a one-cycle done.
module spi_frame_master #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [2:0] ext_addr,
  input  logic [2:0] reg_addr,
  input  logic [7:0] wdata,
  input  logic       miso,
  input  logic       miso_oe,
  output logic       sclk,
  output logic       cs,
  output logic       mosi,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       rd_err
);

  localparam int unsigned      DIV_W    = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]       BIT_LAST = 4'd15;
  localparam int unsigned      FRAME_W  = 16;

  // Address fields go out LSB first, data MSB first.
  typedef struct packed {
    logic       rw;
    logic [2:0] ext_rev;
    logic       rsvd;
    logic [2:0] reg_rev;
    logic [7:0] data;
  } frame_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_TAIL,
    ST_GAP
  } state_e;

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic                 rw_q, rw_d;
  logic [7:0]           rx_q, rx_d;
  logic                 err_q, err_d;
  logic                 sclk_q, sclk_d;
  logic                 cs_q, cs_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [7:0]           rdata_q, rdata_d;
  logic                 rd_err_q, rd_err_d;
  logic                 div_last;
  frame_t               cmd_c;

  assign div_last = (div_cnt_q == DIV_LAST);

  always_comb begin
    cmd_c.rw      = rw;
    cmd_c.ext_rev = {ext_addr[0], ext_addr[1], ext_addr[2]};
    cmd_c.rsvd    = 1'b0;
    cmd_c.reg_rev = {reg_addr[0], reg_addr[1], reg_addr[2]};
    cmd_c.data    = wdata;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)    state_d = ST_LOW;
      ST_LOW:  if (div_last) state_d = ST_HIGH;
      ST_HIGH: if (div_last) state_d = (bit_cnt_q == BIT_LAST) ? ST_TAIL : ST_LOW;
      ST_TAIL: if (div_last) state_d = ST_GAP;
      ST_GAP:  if (div_last) state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; every output is taken from a register.
  always_comb begin
    div_cnt_d = '0;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rw_d      = rw_q;
    rx_d      = rx_q;
    err_d     = err_q;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rdata_d   = rdata_q;
    rd_err_d  = rd_err_q;

    if ((state_q != ST_IDLE) && !div_last) begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_d   = cmd_c;
          rw_d      = rw;
          bit_cnt_d = '0;
          rx_d      = '0;
          err_d     = 1'b0;
          busy_d    = 1'b1;
          cs_d      = 1'b1;
          sclk_d    = 1'b0;
        end
      end
      ST_LOW: begin
        // Rising sclk: miso is taken at the same edge the slave sees.
        if (div_last) begin
          sclk_d = 1'b1;
          if (!rw_q && bit_cnt_q[3]) begin
            rx_d = {rx_q[6:0], miso};
            if (!miso_oe) begin
              err_d = 1'b1;
            end
          end
        end
      end
      ST_HIGH: begin
        if (div_last) begin
          sclk_d = 1'b0;
          if (bit_cnt_q != BIT_LAST) begin
            shift_d   = {shift_q[FRAME_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_TAIL: begin
        if (div_last) begin
          cs_d    = 1'b0;
          shift_d = '0;
          done_d  = 1'b1;
          if (!rw_q) begin
            rdata_d  = rx_q;
            rd_err_d = err_q;
          end
        end
      end
      ST_GAP: begin
        if (div_last) begin
          busy_d = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rw_q      <= 1'b0;
      rx_q      <= '0;
      err_q     <= 1'b0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
      rd_err_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rw_q      <= rw_d;
      rx_q      <= rx_d;
      err_q     <= err_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      rd_err_q  <= rd_err_d;
    end
  end

  assign sclk   = sclk_q;
  assign cs     = cs_q;
  assign mosi   = shift_q[FRAME_W-1];
  assign busy   = busy_q;
  assign done   = done_q;
  assign rdata  = rdata_q;
  assign rd_err = rd_err_q;

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed bench for spi_frame_master: CLK_DIV=2 instance for frame content and
// read/abort cases, CLK_DIV=1 instance for back-to-back throughput.
module tb_spi_frame_master;

  logic       clk;
  logic       rst;
  logic       start;
  logic       start1;
  logic       rw;
  logic [2:0] ext_addr;
  logic [2:0] reg_addr;
  logic [7:0] wdata;
  logic       miso;
  logic       miso_oe;
  logic       sclk, cs, mosi, busy, done, rd_err;
  logic [7:0] rdata;
  logic       sclk1, cs1, mosi1, busy1, done1, rd_err1;
  logic [7:0] rdata1;

  int errors = 0;
  int checks = 0;

  // Frame monitor for the CLK_DIV=2 instance
  int          edge_cnt    = 16;
  int          cs_len      = 0;
  int          last_cs_len = 0;
  int          done_cnt    = 0;
  int          mosi_viol   = 0;
  logic [15:0] mosi_seq    = '0;
  logic        prev_sclk   = 1'b0;
  logic        prev_cs     = 1'b0;
  logic        prev_mosi   = 1'b0;

  // Slave model: data bits MSB first, output-enable chosen per header/data phase
  logic [7:0] slave_byte = 8'h00;
  logic       oe_hdr     = 1'b1;
  logic       oe_data    = 1'b1;

  assign miso    = (edge_cnt >= 8 && edge_cnt < 16) ? slave_byte[3'(15 - edge_cnt)] : 1'b0;
  assign miso_oe = (edge_cnt >= 8) ? oe_data : oe_hdr;

  spi_frame_master #(.CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .ext_addr(ext_addr),
    .reg_addr(reg_addr), .wdata(wdata), .miso(miso), .miso_oe(miso_oe),
    .sclk(sclk), .cs(cs), .mosi(mosi), .busy(busy), .done(done),
    .rdata(rdata), .rd_err(rd_err)
  );

  spi_frame_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .rw(rw), .ext_addr(ext_addr),
    .reg_addr(reg_addr), .wdata(wdata), .miso(miso), .miso_oe(miso_oe),
    .sclk(sclk1), .cs(cs1), .mosi(mosi1), .busy(busy1), .done(done1),
    .rdata(rdata1), .rd_err(rd_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cs && !prev_cs) begin
      edge_cnt <= 0;
      cs_len   <= 1;
    end else if (cs) begin
      cs_len <= cs_len + 1;
      if (sclk && !prev_sclk && edge_cnt < 16) begin
        mosi_seq[4'(15 - edge_cnt)] <= mosi;
        edge_cnt <= edge_cnt + 1;
      end
    end
    if (!cs && prev_cs) last_cs_len <= cs_len;
    if (cs && prev_cs && (mosi !== prev_mosi) && !(prev_sclk && !sclk)) mosi_viol <= mosi_viol + 1;
    if (done) done_cnt <= done_cnt + 1;
    prev_sclk <= sclk;
    prev_cs   <= cs;
    prev_mosi <= mosi;
  end

  task automatic send(input logic r, input logic [2:0] ea, input logic [2:0] ra,
                      input logic [7:0] wd, output logic ok, output logic [7:0] rd_at,
                      output logic er_at, output logic [7:0] rd_before);
    ok = 1'b0; rd_at = '0; er_at = 1'b0; rd_before = rdata;
    @(negedge clk);
    rw = r; ext_addr = ea; reg_addr = ra; wdata = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1; rd_at = rdata; er_at = rd_err;
      end else begin
        rd_before = rdata;
      end
    end
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    checks++;
    if ({sclk, cs, mosi, busy, done, rd_err} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 000000", {sclk, cs, mosi, busy, done, rd_err});
    end
    checks++;
    if (rdata !== 8'h00) begin
      errors++; $display("FAIL reset_rdata: got %h want 00", rdata);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({cs, busy, done, cs1, busy1} !== 5'b0) begin
      errors++; $display("FAIL idle_after_reset: got %b want 00000", {cs, busy, done, cs1, busy1});
    end
  endtask

  task automatic test_write;
    int d0;
    logic ok, er;
    logic [7:0] rd, rb;
    d0 = done_cnt;
    send(1'b1, 3'd7, 3'd7, 8'hAD, ok, rd, er, rb);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL write_done: got %b want 1", ok); end
    checks++;
    if (mosi_seq !== 16'hF7AD) begin errors++; $display("FAIL write_mosi: got %h want F7AD", mosi_seq); end
    checks++;
    if (edge_cnt !== 16) begin errors++; $display("FAIL write_edges: got %0d want 16", edge_cnt); end
    checks++;
    if (last_cs_len !== 66) begin errors++; $display("FAIL write_cs_len: got %0d want 66", last_cs_len); end
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL write_done_cnt: got %0d want 1", done_cnt - d0); end
    checks++;
    if (rd !== 8'h00 || rdata !== 8'h00) begin
      errors++; $display("FAIL write_rdata: got %h/%h want 00/00", rd, rdata);
    end
    checks++;
    if (mosi_viol !== 0) begin errors++; $display("FAIL mosi_timing: got %0d want 0 off-edge changes", mosi_viol); end
  endtask

  task automatic test_read;
    int d0;
    logic ok, er;
    logic [7:0] rd, rb;
    slave_byte = 8'h5A; oe_hdr = 1'b0; oe_data = 1'b1;
    d0 = done_cnt;
    send(1'b0, 3'b101, 3'b010, 8'h00, ok, rd, er, rb);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL read_done: got %b want 1", ok); end
    checks++;
    if (mosi_seq !== 16'h5200) begin errors++; $display("FAIL read_mosi: got %h want 5200", mosi_seq); end
    checks++;
    if (rd !== 8'h5A) begin errors++; $display("FAIL read_rdata: got %h want 5A", rd); end
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL read_rd_err: got %b want 0", er); end
    checks++;
    if (rb !== 8'h00) begin errors++; $display("FAIL read_early_load: got %h want 00", rb); end
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL read_done_cnt: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_read_err;
    logic ok, er;
    logic [7:0] rd, rb;
    slave_byte = 8'hFF; oe_hdr = 1'b1; oe_data = 1'b0;
    send(1'b0, 3'b011, 3'b110, 8'h00, ok, rd, er, rb);
    checks++;
    if (ok !== 1'b1 || rd !== 8'hFF || er !== 1'b1) begin
      errors++; $display("FAIL read_err: got done=%b rdata=%h err=%b want 1/FF/1", ok, rd, er);
    end
    checks++;
    if (rb !== 8'h5A) begin errors++; $display("FAIL read_err_prev: got %h want 5A", rb); end
    oe_data = 1'b1;
    send(1'b1, 3'd0, 3'd0, 8'h11, ok, rd, er, rb);
    checks++;
    if (ok !== 1'b1 || rdata !== 8'hFF || rd_err !== 1'b1) begin
      errors++; $display("FAIL write_keeps_err: got done=%b rdata=%h err=%b want 1/FF/1", ok, rdata, rd_err);
    end
  endtask

  task automatic test_start_busy;
    int d0;
    logic got;
    d0 = done_cnt;
    @(negedge clk);
    rw = 1'b1; ext_addr = 3'b001; reg_addr = 3'b100; wdata = 8'h96; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 400 && edge_cnt != 10; i++) @(negedge clk);
    checks++;
    if (edge_cnt !== 10) begin errors++; $display("FAIL busy_reach_edge10: got %0d want 10", edge_cnt); end
    rw = 1'b0; ext_addr = 3'b110; reg_addr = 3'b011; wdata = 8'h69; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    repeat (60) @(negedge clk);
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL busy_done: got %b want 1", got); end
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL busy_done_cnt: got %0d want 1", done_cnt - d0); end
    checks++;
    if (mosi_seq !== 16'hC196) begin errors++; $display("FAIL busy_mosi: got %h want C196", mosi_seq); end
    checks++;
    if ({busy, cs} !== 2'b00) begin errors++; $display("FAIL busy_idle: got %b want 00", {busy, cs}); end
  endtask

  task automatic test_reset_midframe;
    int d0;
    logic ok, er;
    logic [7:0] rd, rb;
    d0 = done_cnt;
    @(negedge clk);
    rw = 1'b1; ext_addr = 3'd2; reg_addr = 3'd5; wdata = 8'h5F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 400 && edge_cnt != 6; i++) @(negedge clk);
    checks++;
    if (edge_cnt !== 6 || sclk !== 1'b1) begin
      errors++; $display("FAIL abort_reach_edge6: got %0d sclk=%b want 6 sclk=1", edge_cnt, sclk);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({sclk, cs, busy, done} !== 4'b0) begin
      errors++; $display("FAIL abort_outputs: got %b want 0000", {sclk, cs, busy, done});
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt !== d0) begin errors++; $display("FAIL abort_no_done: got %0d want %0d", done_cnt, d0); end
    send(1'b1, 3'd0, 3'd0, 8'h3C, ok, rd, er, rb);
    checks++;
    if (ok !== 1'b1 || mosi_seq !== 16'h803C) begin
      errors++; $display("FAIL post_abort_write: got done=%b mosi=%h want 1/803C", ok, mosi_seq);
    end
    checks++;
    if (last_cs_len !== 66 || rdata !== 8'h00) begin
      errors++; $display("FAIL post_abort_cs: got cs_len=%0d rdata=%h want 66/00", last_cs_len, rdata);
    end
  endtask

  task automatic test_back_to_back;
    int cs_run, busy_lo, frames, dones, mosi_bad;
    logic seen_busy;
    cs_run = 0; busy_lo = 0; frames = 0; dones = 0; mosi_bad = 0; seen_busy = 1'b0;
    @(negedge clk);
    rw = 1'b1; ext_addr = 3'b010; reg_addr = 3'b001; wdata = 8'hA5; start1 = 1'b1;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (done1) dones++;
      if (!cs1 && mosi1) mosi_bad++;
      if (cs1) begin
        cs_run++;
      end else if (cs_run > 0) begin
        checks++;
        if (cs_run !== 33) begin errors++; $display("FAIL b2b_cs_len: got %0d want 33", cs_run); end
        frames++;
        cs_run = 0;
      end
      if (!busy1) begin
        busy_lo++;
      end else begin
        if (seen_busy && busy_lo > 0) begin
          checks++;
          if (busy_lo !== 1) begin errors++; $display("FAIL b2b_busy_low: got %0d want 1", busy_lo); end
        end
        busy_lo = 0;
        seen_busy = 1'b1;
      end
    end
    start1 = 1'b0;
    for (int i = 0; i < 100 && busy1; i++) @(negedge clk);
    checks++;
    if (frames < 6) begin errors++; $display("FAIL b2b_frames: got %0d want >=6", frames); end
    checks++;
    if (dones !== frames) begin errors++; $display("FAIL b2b_done_cnt: got %0d want %0d", dones, frames); end
    checks++;
    if (mosi_bad !== 0 || rdata1 !== 8'h00 || rd_err1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got mosi_bad=%0d rdata=%h err=%b busy=%b want 0/00/0/0",
               mosi_bad, rdata1, rd_err1, busy1);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; start1 = 1'b0; rw = 1'b0;
    ext_addr = '0; reg_addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_read_err();
    test_start_busy();
    test_reset_midframe();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
